// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module  : pc_sequencer_pkg
// Purpose : Shared definitions for the kt8 fetch/decode/execute sequencer.
//           Holds the FSM state encoding, the branch opcode fields, the
//           default halt opcode and the index of the branch condition bit.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

  // ST_PAUSE is only reachable when PC_SEQUENCER_SINGLE_STEP_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5,
    ST_PAUSE  = 3'd6
  } state_e;

  // Branch opcodes live in instruction bits [7:5].
  localparam logic [2:0] BR_UP_OP            = 3'b110;
  localparam logic [2:0] BR_DN_OP            = 3'b111;
  localparam logic [7:0] HALT_OPCODE_DEFAULT = 8'hBF;

  // Bit 4 selects conditional (on Z) versus unconditional branching.
  localparam int COND_BIT = 4;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_branch_decode.sv
// ============================================================================
// Module  : pc_sequencer_branch_decode
// Purpose : Purely combinational decode of a latched kt8 instruction byte.
//           Classifies it as branch / halt / plain and resolves whether a
//           branch is taken against the supplied Z flag.
// Ports   : instr_i[7:0]  instruction byte
//           flag_z_i      zero flag used by conditional branches
//           is_branch_o   opcode field is a branch (up or down)
//           taken_o       branch is taken
//           up_o/down_o   taken branch direction (mutually exclusive)
//           dist_o[3:0]   jump distance field
//           is_halt_o     byte equals HALT_OPCODE
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer_branch_decode
  import pc_sequencer_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic [7:0] instr_i,
  input  logic       flag_z_i,
  output logic       is_branch_o,
  output logic       taken_o,
  output logic       up_o,
  output logic       down_o,
  output logic [3:0] dist_o,
  output logic       is_halt_o
);

  logic [2:0] w_op;
  logic       w_op_up;
  logic       w_op_dn;

  assign w_op    = instr_i[7:5];
  assign w_op_up = (w_op == BR_UP_OP);
  assign w_op_dn = (w_op == BR_DN_OP);

  // Halt has priority so a halt opcode overlapping a branch encoding never
  // also produces a jump.
  assign is_halt_o   = (instr_i == HALT_OPCODE);
  assign is_branch_o = (w_op_up | w_op_dn) & ~is_halt_o;
  assign taken_o     = is_branch_o & (~instr_i[COND_BIT] | flag_z_i);
  assign up_o        = taken_o & w_op_up;
  assign down_o      = taken_o & w_op_dn;
  assign dist_o      = instr_i[3:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Purpose : Fetch/decode/execute sequencer for the kt8 program counter.
//           Requests instruction bytes, decodes branches against Z and issues
//           exactly one PC step per instruction. All outputs are registered.
// Params  : FETCH_TIMEOUT  cycles in FETCH without ack before fault (1..255)
//           HALT_OPCODE    instruction byte that halts the sequencer
// Macro   : PC_SEQUENCER_SINGLE_STEP_EN adds step_i and a PAUSE state after
//           every EXEC; one step_i rising edge releases one instruction.
// Ports   : clk_i, rst_i (async, active-high)
//           run_i, instr_i[7:0], instr_valid_i, flag_z_i, [step_i]
//           fetch_req_o, pc_step_o, pc_jump_up_o, pc_jump_down_o,
//           pc_jump_dist_o[3:0], exec_o, instr_o[7:0], halted_o, fault_o
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter logic [7:0]  HALT_OPCODE   = HALT_OPCODE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [7:0] instr_i,
  input  logic       instr_valid_i,
  input  logic       flag_z_i,
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
  input  logic       step_i,
`endif
  output logic       fetch_req_o,
  output logic       pc_step_o,
  output logic       pc_jump_up_o,
  output logic       pc_jump_down_o,
  output logic [3:0] pc_jump_dist_o,
  output logic       exec_o,
  output logic [7:0] instr_o,
  output logic       halted_o,
  output logic       fault_o
);

  // Last counter value still spent in FETCH; the next miss faults.
  localparam logic [7:0] C_TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] instr_q, instr_d;
  logic       fetch_req_q, fetch_req_d;
  logic       pc_step_q, pc_step_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic [3:0] dist_q, dist_d;
  logic       exec_q, exec_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;

  logic       w_is_branch;
  logic       w_taken;
  logic       w_up;
  logic       w_down;
  logic [3:0] w_dist;
  logic       w_is_halt;

`ifdef PC_SEQUENCER_SINGLE_STEP_EN
  logic step_q;
  logic w_step_rise;
  assign w_step_rise = step_i & ~step_q;
`endif

  // Decodes the latched byte; flag_z_i is only consumed on the DECODE->EXEC
  // edge, so later flag changes cannot alter the branch outcome.
  pc_sequencer_branch_decode #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_branch_decode (
    .instr_i     (instr_q),
    .flag_z_i    (flag_z_i),
    .is_branch_o (w_is_branch),
    .taken_o     (w_taken),
    .up_o        (w_up),
    .down_o      (w_down),
    .dist_o      (w_dist),
    .is_halt_o   (w_is_halt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    pc_step_d = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    dist_d    = 4'h0;
    exec_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // A valid ack on the timeout cycle still wins over the fault.
        if (instr_valid_i) begin
          instr_d = instr_i;
          cnt_d   = 8'h00;
          state_d = ST_DECODE;
        end else if (cnt_q == C_TO_LAST) begin
          cnt_d   = 8'h00;
          state_d = ST_FAULT;
        end else begin
          cnt_d   = cnt_q + 8'h01;
        end
      end
      ST_DECODE: begin
        if (w_is_halt) begin
          state_d = ST_HALTED;
        end else begin
          // EXEC strobes are prepared here so they appear registered in EXEC.
          state_d   = ST_EXEC;
          pc_step_d = 1'b1;
          up_d      = w_up;
          down_d    = w_down;
          dist_d    = w_taken ? w_dist : 4'h0;
          exec_d    = ~w_is_branch;
        end
      end
      ST_EXEC: begin
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
        state_d = ST_PAUSE;
`else
        state_d = run_i ? ST_FETCH : ST_IDLE;
`endif
      end
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (w_step_rise) state_d = run_i ? ST_FETCH : ST_IDLE;
      end
`endif
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    fetch_req_d = (state_d == ST_FETCH);
    halted_d    = (state_d == ST_HALTED);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      instr_q     <= 8'h00;
      fetch_req_q <= 1'b0;
      pc_step_q   <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      dist_q      <= 4'h0;
      exec_q      <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      step_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      fetch_req_q <= fetch_req_d;
      pc_step_q   <= pc_step_d;
      up_q        <= up_d;
      down_q      <= down_d;
      dist_q      <= dist_d;
      exec_q      <= exec_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      step_q      <= step_i;
`endif
    end
  end

  assign fetch_req_o    = fetch_req_q;
  assign pc_step_o      = pc_step_q;
  assign pc_jump_up_o   = up_q;
  assign pc_jump_down_o = down_q;
  assign pc_jump_dist_o = dist_q;
  assign exec_o         = exec_q;
  assign instr_o        = instr_q;
  assign halted_o       = halted_q;
  assign fault_o        = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Directed self-checking bench for pc_sequencer. Outputs are
//           sampled on the falling clock edge and packed into a flag byte:
//           [6] fetch_req [5] pc_step [4] jump_up [3] jump_down
//           [2] exec [1] halted [0] fault
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;

  localparam int unsigned FETCH_TIMEOUT = 8;

  logic       clk_i         = 1'b0;
  logic       rst_i         = 1'b1;
  logic       run_i         = 1'b0;
  logic [7:0] instr_i       = 8'h00;
  logic       instr_valid_i = 1'b0;
  logic       flag_z_i      = 1'b0;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
  logic       step_i        = 1'b0;
`endif
  logic       fetch_req_o;
  logic       pc_step_o;
  logic       pc_jump_up_o;
  logic       pc_jump_down_o;
  logic [3:0] pc_jump_dist_o;
  logic       exec_o;
  logic [7:0] instr_o;
  logic       halted_o;
  logic       fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  pc_sequencer #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .HALT_OPCODE   (8'hBF)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .run_i          (run_i),
    .instr_i        (instr_i),
    .instr_valid_i  (instr_valid_i),
    .flag_z_i       (flag_z_i),
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
    .step_i         (step_i),
`endif
    .fetch_req_o    (fetch_req_o),
    .pc_step_o      (pc_step_o),
    .pc_jump_up_o   (pc_jump_up_o),
    .pc_jump_down_o (pc_jump_down_o),
    .pc_jump_dist_o (pc_jump_dist_o),
    .exec_o         (exec_o),
    .instr_o        (instr_o),
    .halted_o       (halted_o),
    .fault_o        (fault_o)
  );

  function automatic logic [7:0] flags();
    return {1'b0, fetch_req_o, pc_step_o, pc_jump_up_o, pc_jump_down_o,
            exec_o, halted_o, fault_o};
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  // Releases a paused sequencer with one step_i pulse; no-op otherwise.
  task automatic nudge();
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
    @(negedge clk_i); step_i = 1'b1;
    @(negedge clk_i); step_i = 1'b0;
`endif
  endtask

  // Waits (bounded) for a fetch request, acks with byte b, checks the DECODE
  // cycle and returns on the falling edge inside EXEC (or HALTED).
  task automatic do_instr(input logic [7:0] b, output int waited);
    nudge();
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!fetch_req_o && waited < 20);
    check("fetch_req", {7'd0, fetch_req_o}, 8'h01);
    instr_i       = b;
    instr_valid_i = 1'b1;
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    check("decode_idle", flags(), 8'h00);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int steps;
    #1;
    check("rst_flags", flags(), 8'h00);
    check("rst_instr", instr_o, 8'h00);
    check("rst_dist", {4'h0, pc_jump_dist_o}, 8'h00);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    run_i = 1'b1;

    // Plain instructions: step + exec, no jumps, 3 cycles apart.
    for (int k = 0; k < 3; k++) begin
      do_instr(8'h01, w);
      check("plain_exec", flags(), 8'h24);
      check("plain_dist", {4'h0, pc_jump_dist_o}, 8'h00);
      check("plain_instr", instr_o, 8'h01);
`ifndef PC_SEQUENCER_SINGLE_STEP_EN
      check("plain_gap", 8'(w), 8'd1);
`endif
    end
    run_i = 1'b0;
    @(negedge clk_i);
    check("step_one_shot", flags(), 8'h00);
    repeat (2) @(negedge clk_i);
    check("idle_no_req", flags(), 8'h00);

    // Branch up: unconditional taken, then conditional not taken.
    run_i    = 1'b1;
    flag_z_i = 1'b0;
    do_instr(8'hC5, w);
    check("up_taken", flags(), 8'h30);
    check("up_dist", {4'h0, pc_jump_dist_o}, 8'h05);
    check("up_instr", instr_o, 8'hC5);
    do_instr(8'hD5, w);
    check("up_not_taken", flags(), 8'h20);
    check("up_nt_dist", {4'h0, pc_jump_dist_o}, 8'h00);

    // Branch down conditional: Z sampled in DECODE, dropped in EXEC.
    flag_z_i = 1'b1;
    do_instr(8'hF6, w);
    flag_z_i = 1'b0;
    check("dn_taken", flags(), 8'h28);
    check("dn_dist", {4'h0, pc_jump_dist_o}, 8'h06);
    do_instr(8'hE0, w);
    check("dn_dist0_self_loop", flags(), 8'h28);
    check("dn_dist0", {4'h0, pc_jump_dist_o}, 8'h00);
    do_instr(8'hF6, w);
    check("dn_not_taken", flags(), 8'h20);

    // Reset asserted between edges while FETCH is active.
    nudge();
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (!fetch_req_o && w < 20);
    check("midfetch_req", {7'd0, fetch_req_o}, 8'h01);
    #2 rst_i = 1'b1;
    #1;
    check("midfetch_rst_flags", flags(), 8'h00);
    check("midfetch_rst_instr", instr_o, 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Halt: sticky, no requests or steps afterwards.
    do_instr(8'hBF, w);
    check("halt_flags", flags(), 8'h02);
    check("halt_instr", instr_o, 8'hBF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("halt_hold", flags(), 8'h02);
    end
    #2 rst_i = 1'b1;
    #1;
    check("halt_rst", flags(), 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Valid arriving on the last permitted FETCH cycle wins over the fault.
    repeat (7) @(negedge clk_i);
    @(negedge clk_i);
    check("to_last_fetch", flags(), 8'h40);
    instr_i       = 8'h01;
    instr_valid_i = 1'b1;
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    check("to_valid_wins", flags(), 8'h00);
    @(negedge clk_i);
    check("to_valid_exec", flags(), 8'h24);
    run_i = 1'b0;
    nudge();

    // Full timeout: 8 FETCH cycles without ack, then sticky fault.
    @(negedge clk_i);
    run_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("to_8th_fetch", flags(), 8'h40);
    @(negedge clk_i);
    check("to_fault", flags(), 8'h01);
    run_i         = 1'b0;
    instr_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    instr_valid_i = 1'b0;
    check("fault_sticky", flags(), 8'h01);
    #2 rst_i = 1'b1;
    #1;
    check("fault_rst", flags(), 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;

`ifdef PC_SEQUENCER_SINGLE_STEP_EN
    // Single step: step_i held high for 5 cycles releases one instruction.
    run_i = 1'b1;
    do_instr(8'h01, w);
    check("ss_exec", flags(), 8'h24);
    repeat (3) @(negedge clk_i);
    check("ss_paused", flags(), 8'h00);
    step_i = 1'b1;
    steps  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (c == 4) step_i = 1'b0;
      if (pc_step_o) steps++;
      instr_valid_i = fetch_req_o;
      instr_i       = 8'h01;
    end
    instr_valid_i = 1'b0;
    check("ss_one_instr", 8'(steps), 8'd1);
    check("ss_paused_again", flags(), 8'h00);
`else
    steps = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/execute sequencer for the kt8 program counter.
- Requests instruction bytes from program memory and decodes branch opcodes against the Z flag.
- Issues exactly one PC step per instruction, with jump_up/jump_down/jump_distance driving the PC's jump inputs.
- Sits between program memory, the flag register and the pc block; the PC advances only on cycles where pc_step_o is high.

Parameters:
- FETCH_TIMEOUT, 15: max cycles in FETCH without instr_valid_i before fault (1..255).
- HALT_OPCODE, 8'hBF: instruction byte that halts the sequencer.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. Asynchronous, active-high.
- run_i  in  1  level; start/continue sequencing.
- instr_i  in  8  instruction byte from program memory.
- instr_valid_i  in  1  memory ack; instr_i valid this cycle.
- flag_z_i  in  1  zero flag from datapath.
- fetch_req_o  out  1  request next instruction at current PC.
- pc_step_o  out  1  one-cycle PC advance strobe.
- pc_jump_up_o  out  1  step is forward jump.
- pc_jump_down_o  out  1  step is backward jump.
- pc_jump_dist_o  out  4  jump distance.
- exec_o  out  1  one-cycle strobe: datapath executes latched non-branch instruction.
- instr_o  out  8  latched instruction.
- halted_o  out  1  sticky, set on HALT_OPCODE.
- fault_o  out  1  sticky, set on fetch timeout.

Behaviour:
- Reset (async, immediate): state IDLE; every output 0; instr_o=8'h00; timeout counter 0. Reset mid-instruction abandons it, with no PC step.
- All outputs registered (Moore).
- Encoding:
  - [7:5]=110: branch up.
  - [7:5]=111: branch down.
  - [4]: 0=always, 1=if flag_z_i.
  - [3:0]: distance.
  - HALT_OPCODE: halt.
  - Anything else: plain instruction.
- States:
  - IDLE: outputs 0. run_i=1 -> FETCH next cycle.
  - FETCH: fetch_req_o=1, counter increments each cycle.
    - instr_valid_i=1: latch instr_i into instr_o, clear counter -> DECODE.
    - Counter reaches FETCH_TIMEOUT with no valid -> FAULT.
    - Valid on the same cycle as the timeout: valid wins.
  - DECODE: one cycle. flag_z_i is sampled here only; later flag changes are ignored.
    - HALT_OPCODE -> HALTED.
    - Otherwise -> EXEC.
  - EXEC: one cycle.
    - pc_step_o=1.
    - Taken branch: pc_jump_up_o or pc_jump_down_o=1, pc_jump_dist_o=[3:0].
    - Not-taken branch: plain increment; jump outputs 0, dist 0.
    - Plain instruction: exec_o=1, increment.
    - Next state: run_i=1 -> FETCH, else IDLE.
  - HALTED: halted_o=1, no further requests. Exits only via reset.
  - FAULT: fault_o=1, fetch_req_o=0. Exits only via reset.
- Jump up and jump down are never both asserted. Jump outputs are 0 whenever pc_step_o=0.
- Taken branch with distance 0: PC holds (self-loop). This is legal and not a fault.
- Throughput: minimum 3 cycles per instruction (FETCH 1 + DECODE + EXEC).
- run_i deassert during FETCH/DECODE: the current instruction completes, then IDLE.
- instr_valid_i outside FETCH: ignored.
- PC wrap-around 8'hFF->8'h00 is the pc's responsibility. The sequencer never tracks PC value.

Optional Feature:
- Macro: PC_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input step_i (1 bit) and state PAUSE.
  - EXEC always -> PAUSE, regardless of run_i.
  - PAUSE holds all strobes 0 until a step_i rising edge (registered edge detect).
  - Then: run_i=1 -> FETCH, else IDLE.
  - step_i held high advances one instruction only.
- Undefined: no step_i port, no PAUSE state; EXEC transitions as above.

Decomposition:
- Shared include kt8_defs.vh holds:
  - State encodings (IDLE, FETCH, DECODE, EXEC, HALTED, FAULT, PAUSE).
  - Opcode constants: BR_UP_OP=3'b110, BR_DN_OP=3'b111, HALT_OPCODE default.
  - Condition bit index.
- One combinational sub-module, branch_decode:
  - Inputs: instr[7:0], flag_z.
  - Outputs: is_branch, taken, up, down, dist[3:0], is_halt.
- The FSM, timeout counter and output registers stay in pc_sequencer.

Test Plan:
- Plain run: rst 1->0, run_i=1, memory acks every FETCH cycle with 8'h01 ×3 -> 3 pc_step_o pulses with exec_o, no jump outputs, 3 cycles apart.
- Branch up taken: instr 8'hC5, flag_z=0 -> EXEC shows pc_jump_up_o=1, dist=5. Instr 8'hD5 with flag_z=0 -> plain step, dist=0, exec_o=0.
- Branch down conditional: instr 8'hF6, flag_z=1 sampled in DECODE; flag_z dropped to 0 in EXEC -> pc_jump_down_o=1, dist=6.
- Timeout: FETCH_TIMEOUT=8, no instr_valid_i -> fault_o=1 after 8 FETCH cycles, fetch_req_o=0, no pc_step_o. Only rst_i clears it.
- Halt and reset: instr 8'hBF -> halted_o=1, no pc_step_o, fetch_req_o stays 0 for 10 cycles. Asserting rst_i mid-FETCH (between clock edges) clears all outputs immediately.
- Single step (PC_SEQUENCER_SINGLE_STEP_EN): run_i=1, step_i held high for 5 cycles -> exactly one further instruction executes.
